// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch > CPU access > bulk fill, one RAM op per cycle.
// CPU read path is built only when VRAM_CPU_READ_EN is defined.
module vram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   cpu_a,
  input  logic [31:0]   cpu_d,
  input  logic          cpu_we,
  input  logic          cpu_rd,
  output logic [31:0]   cpu_spo,
  output logic          cpu_ready,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_a,
  output logic [DW-1:0] disp_q,
  output logic          disp_valid,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_val,
  output logic          fill_busy,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  localparam logic [AW-1:0] LAST_ADDR = '1;

`ifdef VRAM_CPU_READ_EN
  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_WR_PEND = 2'd1,
    C_RD_PEND = 2'd2,
    C_RD_WAIT = 2'd3
  } cpu_state_e;
`else
  typedef enum logic {
    C_IDLE    = 1'b0,
    C_WR_PEND = 1'b1
  } cpu_state_e;
`endif

  cpu_state_e    state_q;
  logic          sub_q;
  logic          cpu_ready_q;
  logic [AW-1:0] cpu_addr_q;
  logic [DW-1:0] cpu_data_q;
  logic [31:0]   cpu_spo_q;

  logic          fill_busy_q;
  logic [AW-1:0] fill_addr_q;
  logic [DW-1:0] fill_val_q;

  logic          disp_p1_q, disp_p2_q, disp_valid_q;
  logic [DW-1:0] disp_q_q;

  logic [AW-1:0] ram_a_q;
  logic [DW-1:0] ram_d_q;
  logic          ram_we_q;

  logic cpu_wants, grant_cpu, grant_fill;

  always_comb begin
    cpu_wants = (state_q == C_WR_PEND) && !sub_q;
`ifdef VRAM_CPU_READ_EN
    if (state_q == C_RD_PEND) cpu_wants = 1'b1;
`endif
    grant_cpu  = !disp_req && cpu_wants;
    grant_fill = !disp_req && !cpu_wants && fill_busy_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= C_IDLE;
      sub_q        <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_data_q   <= '0;
      cpu_spo_q    <= '0;
      fill_busy_q  <= 1'b0;
      fill_addr_q  <= '0;
      fill_val_q   <= '0;
      disp_p1_q    <= 1'b0;
      disp_p2_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_q_q     <= '0;
      ram_a_q      <= '0;
      ram_d_q      <= '0;
      ram_we_q     <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      if (disp_req) begin
        ram_a_q <= disp_a;
      end else if (grant_cpu) begin
        ram_a_q  <= cpu_addr_q;
        ram_d_q  <= cpu_data_q;
        ram_we_q <= (state_q == C_WR_PEND);
      end else if (grant_fill) begin
        ram_a_q     <= fill_addr_q;
        ram_d_q     <= fill_val_q;
        ram_we_q    <= 1'b1;
        fill_addr_q <= fill_addr_q + 1'b1;
        if (fill_addr_q == LAST_ADDR) fill_busy_q <= 1'b0;
      end

      if (fill_start && !fill_busy_q) begin
        fill_busy_q <= 1'b1;
        fill_addr_q <= '0;
        fill_val_q  <= fill_val;
      end

      // ram_q is valid two cycles after the request cycle; register it once more
      disp_p1_q    <= disp_req;
      disp_p2_q    <= disp_p1_q;
      disp_valid_q <= disp_p2_q;
      if (disp_p2_q) disp_q_q <= ram_q;

      // sub_q marks the second cycle of a two-cycle hold in WR_PEND / RD_WAIT
      case (state_q)
        C_IDLE: begin
          if (cpu_ready_q && cpu_we) begin
            cpu_addr_q  <= cpu_a[AW+1:2];
            cpu_data_q  <= {cpu_d[23:16], cpu_d[31:24]};
            state_q     <= C_WR_PEND;
            sub_q       <= 1'b0;
            cpu_ready_q <= 1'b0;
`ifdef VRAM_CPU_READ_EN
          end else if (cpu_ready_q && cpu_rd) begin
            cpu_addr_q  <= cpu_a[AW+1:2];
            state_q     <= C_RD_PEND;
            sub_q       <= 1'b0;
            cpu_ready_q <= 1'b0;
`endif
          end else begin
            cpu_ready_q <= 1'b1;
          end
        end
        C_WR_PEND: begin
          if (sub_q) begin
            state_q     <= C_IDLE;
            sub_q       <= 1'b0;
            cpu_ready_q <= 1'b1;
          end else if (grant_cpu) begin
            sub_q <= 1'b1;
          end
        end
`ifdef VRAM_CPU_READ_EN
        C_RD_PEND: begin
          if (grant_cpu) begin
            state_q <= C_RD_WAIT;
            sub_q   <= 1'b0;
          end
        end
        C_RD_WAIT: begin
          if (sub_q) begin
            cpu_spo_q   <= {16'b0, ram_q[7:0], ram_q[15:8]};
            state_q     <= C_IDLE;
            sub_q       <= 1'b0;
            cpu_ready_q <= 1'b1;
          end else begin
            sub_q <= 1'b1;
          end
        end
`endif
        default: state_q <= C_IDLE;
      endcase
    end
  end

`ifdef VRAM_CPU_READ_EN
  assign cpu_spo = cpu_spo_q;
  logic unused_bits;
  assign unused_bits = ^{cpu_a[1:0], cpu_a[31:AW+2], cpu_d[15:0]};
`else
  assign cpu_spo = '0;
  logic unused_bits;
  assign unused_bits = ^{cpu_a[1:0], cpu_a[31:AW+2], cpu_d[15:0], cpu_rd, cpu_spo_q};
`endif

  assign cpu_ready  = cpu_ready_q;
  assign disp_q     = disp_q_q;
  assign disp_valid = disp_valid_q;
  assign fill_busy  = fill_busy_q;
  assign ram_a      = ram_a_q;
  assign ram_d      = ram_d_q;
  assign ram_we     = ram_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 1-cycle-latency RAM model.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_a = '0, cpu_d = '0;
  logic        cpu_we = 1'b0, cpu_rd = 1'b0;
  logic [31:0] cpu_spo;
  logic        cpu_ready;
  logic        disp_req = 1'b0;
  logic [11:0] disp_a = '0;
  logic [15:0] disp_q;
  logic        disp_valid;
  logic        fill_start = 1'b0;
  logic [15:0] fill_val = '0;
  logic        fill_busy;
  logic [11:0] ram_a;
  logic [15:0] ram_d;
  logic        ram_we;
  logic [15:0] ram_q;

  logic [15:0] mem [4096];
  logic        pre_we = 1'b0;
  logic [11:0] pre_a = '0;
  logic [15:0] pre_d = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (ram_we) mem[ram_a] <= ram_d;
    ram_q <= mem[ram_a];
  end

  vram_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
    .cpu_spo(cpu_spo), .cpu_ready(cpu_ready),
    .disp_req(disp_req), .disp_a(disp_a), .disp_q(disp_q), .disp_valid(disp_valid),
    .fill_start(fill_start), .fill_val(fill_val), .fill_busy(fill_busy),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int bad;
    bit found;

    // reset state
    tick(); tick();
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_fill_busy", 32'(fill_busy), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_a", 32'(ram_a), 32'd0);
    check("rst_cpu_spo", cpu_spo, 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(cpu_ready), 32'd1);

    pre_we = 1'b1; pre_a = 12'h050; pre_d = 16'h1F41;
    tick();
    pre_we = 1'b0;
    tick();

    // display fetch, 3-cycle latency
    disp_req = 1'b1; disp_a = 12'h050;
    tick();
    disp_req = 1'b0;
    check("disp_ram_a", 32'(ram_a), 32'h050);
    check("disp_ram_we", 32'(ram_we), 32'd0);
    check("disp_valid_n1", 32'(disp_valid), 32'd0);
    tick();
    check("disp_valid_n2", 32'(disp_valid), 32'd0);
    tick();
    check("disp_valid_n3", 32'(disp_valid), 32'd1);
    check("disp_q_n3", 32'(disp_q), 32'h1F41);
    tick();
    check("disp_valid_n4", 32'(disp_valid), 32'd0);

    // CPU write colliding with a display fetch
    disp_req = 1'b1; disp_a = 12'h010;
    cpu_we = 1'b1; cpu_a = 32'h0000_0140; cpu_d = 32'h4107_0000;
    check("wr_ready_pre", 32'(cpu_ready), 32'd1);
    tick();
    disp_req = 1'b0; cpu_we = 1'b0;
    check("wr_disp_first_a", 32'(ram_a), 32'h010);
    check("wr_disp_first_we", 32'(ram_we), 32'd0);
    check("wr_ready_n1", 32'(cpu_ready), 32'd0);
    tick();
    check("wr_we", 32'(ram_we), 32'd1);
    check("wr_a", 32'(ram_a), 32'h050);
    check("wr_d", 32'(ram_d), 32'h0741);
    check("wr_ready_n2", 32'(cpu_ready), 32'd0);
    tick();
    check("wr_ready_n3", 32'(cpu_ready), 32'd1);
    check("wr_mem", 32'(mem[12'h050]), 32'h0741);

    // CPU write stalled behind a 5-cycle display burst
    disp_req = 1'b1; disp_a = 12'h020;
    cpu_we = 1'b1; cpu_a = 32'h0000_000C; cpu_d = 32'hBBAA_0000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      cpu_we = 1'b0;
      if (k == 5) disp_req = 1'b0;
      check($sformatf("burst_we_%0d", k), 32'(ram_we), 32'd0);
    end
    check("burst_last_disp_a", 32'(ram_a), 32'h020);
    tick();
    check("burst_wr_we", 32'(ram_we), 32'd1);
    check("burst_wr_a", 32'(ram_a), 32'h003);
    check("burst_wr_d", 32'(ram_d), 32'hAABB);
    tick(); tick();

    // CPU read
    cpu_rd = 1'b1; cpu_a = 32'h0000_0140;
    tick();
    cpu_rd = 1'b0;
`ifdef VRAM_CPU_READ_EN
    cnt = 1;
    while (!cpu_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    check("rd_latency", 32'(cnt), 32'd4);
    check("rd_spo", cpu_spo, 32'h0000_4107);
`else
    check("rd_ready", 32'(cpu_ready), 32'd1);
    check("rd_spo", cpu_spo, 32'd0);
    tick();
    check("rd_ready_n2", 32'(cpu_ready), 32'd1);
    check("rd_no_we", 32'(ram_we), 32'd0);
`endif
    tick(); tick();

    // fill, with an ignored restart partway through
    fill_start = 1'b1; fill_val = 16'h0720;
    tick();
    fill_start = 1'b0;
    check("fill_busy_start", 32'(fill_busy), 32'd1);
    cnt = 0;
    while (fill_busy && cnt < 5000) begin
      cnt++;
      if (cnt == 100) begin
        fill_start = 1'b1; fill_val = 16'h1234;
      end else begin
        fill_start = 1'b0;
      end
      tick();
    end
    check("fill_busy_cycles", 32'(cnt), 32'd4096);
    tick();
    bad = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== 16'h0720) bad++;
    check("fill_bad_cells", 32'(bad), 32'd0);
    check("fill_cell_050", 32'(mem[12'h050]), 32'h0720);
    check("fill_cell_fff", 32'(mem[12'hFFF]), 32'h0720);

    // reset in the middle of a fill
    fill_start = 1'b1; fill_val = 16'h5555;
    tick();
    fill_start = 1'b0;
    found = 1'b0;
    cnt = 0;
    while (!found && cnt < 5000) begin
      if (ram_we && ram_a == 12'h800) found = 1'b1;
      else begin
        tick();
        cnt++;
      end
    end
    check("fill_reached_800", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ram_we", 32'(ram_we), 32'd0);
    check("mid_rst_ram_a", 32'(ram_a), 32'd0);
    check("mid_rst_ram_d", 32'(ram_d), 32'd0);
    check("mid_rst_fill_busy", 32'(fill_busy), 32'd0);
    check("mid_rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("mid_rst_disp_valid", 32'(disp_valid), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_fill_busy", 32'(fill_busy), 32'd0);
    check("post_rst_ready", 32'(cpu_ready), 32'd1);
    check("cell_7ff_filled", 32'(mem[12'h7FF]), 32'h5555);
    check("cell_800_kept", 32'(mem[12'h800]), 32'h0720);
    check("cell_fff_kept", 32'(mem[12'hFFF]), 32'h0720);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
